// File: rtl/hfosc_ctrl.sv
// rtl/hfosc_ctrl.sv - SB_HFOSC power-up/enable sequencer with HF activity monitor
module hfosc_ctrl #(
  parameter int PU_CYCLES  = 100,
  parameter int EDGES_MIN  = 4,
  parameter int START_TMO  = 64,
  parameter int WDOG       = 16,
  parameter int OFF_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       hf_tgl,
  output logic       clkhfpu,
  output logic       clkhfen,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  // One shared cycle counter serves every timed state, so it is sized for the
  // largest interval any parameter can ask for.
  localparam int M1   = (PU_CYCLES > START_TMO) ? PU_CYCLES : START_TMO;
  localparam int M2   = (WDOG > OFF_CYCLES) ? WDOG : OFF_CYCLES;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXP = (M3 > EDGES_MIN) ? M3 : EDGES_MIN;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int EW   = $clog2(EDGES_MIN + 1);

  // Terminal counts: a state of N cycles exits when the counter shows N-1.
  localparam logic [CW-1:0] PU_LAST   = CW'(PU_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(START_TMO - 1);
  localparam logic [CW-1:0] WD_LAST   = CW'(WDOG - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(EDGES_MIN - 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWRUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_READY  = 3'd3,
    S_SHUTDN = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  logic [2:0]    st;
  state_t        nxt;
  logic          cnt_clr;
  logic [CW-1:0] cnt;
  logic [EW-1:0] ecnt;
  logic          sync1, sync2, hist;
  logic          act;

  // Bring the HF-domain toggle into clk and keep one history stage for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= hf_tgl;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Any change of the synchronized level is one activity edge.
  assign act = sync2 ^ hist;

  // Next-state decision; the counter keeps running only while the state holds.
  always_comb begin
    nxt     = S_OFF;
    cnt_clr = 1'b1;
    case (st)
      S_OFF:    nxt = req ? S_PWRUP : S_OFF;
      S_PWRUP: begin
        if (!req)                nxt = S_SHUTDN;
        else if (cnt == PU_LAST) nxt = S_ENABLE;
        else begin
          nxt     = S_PWRUP;
          cnt_clr = 1'b0;
        end
      end
      S_ENABLE: begin
        // A completing edge beats a timeout landing on the same cycle.
        if (!req)                            nxt = S_SHUTDN;
        else if (act && (ecnt == EDGE_LAST)) nxt = S_READY;
        else if (cnt == TMO_LAST)            nxt = S_FAULT;
        else begin
          nxt     = S_ENABLE;
          cnt_clr = 1'b0;
        end
      end
      S_READY: begin
        // Dropping req wins over a watchdog expiry in the same cycle.
        if (!req)                nxt = S_SHUTDN;
        else if (act)            nxt = S_READY;
        else if (cnt == WD_LAST) nxt = S_FAULT;
        else begin
          nxt     = S_READY;
          cnt_clr = 1'b0;
        end
      end
      S_SHUTDN: begin
        if (cnt == OFF_LAST) nxt = S_OFF;
        else begin
          nxt     = S_SHUTDN;
          cnt_clr = 1'b0;
        end
      end
      S_FAULT:  nxt = req ? S_FAULT : S_OFF;
      default:  nxt = S_OFF;
    endcase
  end

  // State, saturating counters and outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_OFF;
      cnt     <= '0;
      ecnt    <= '0;
      clkhfpu <= 1'b0;
      clkhfen <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      st <= nxt;
      if (cnt_clr)           cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + CW'(1);
      if ((st == S_ENABLE) && (nxt == S_ENABLE)) begin
        if (act && (ecnt != '1)) ecnt <= ecnt + EW'(1);
      end else begin
        ecnt <= '0;
      end
      clkhfpu <= (nxt == S_PWRUP) || (nxt == S_ENABLE) ||
                 (nxt == S_READY) || (nxt == S_SHUTDN);
      clkhfen <= (nxt == S_ENABLE) || (nxt == S_READY);
      ready   <= (nxt == S_READY);
      fault   <= (nxt == S_FAULT);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_hfosc_ctrl.sv
// tb/tb_hfosc_ctrl.sv - randomized and directed bench for hfosc_ctrl
module tb_hfosc_ctrl;

  localparam int PU   = 100;
  localparam int EMIN = 4;
  localparam int TMO  = 64;
  localparam int WD   = 16;
  localparam int OFFC = 8;

  localparam int M_OFF = 0, M_PWRUP = 1, M_ENABLE = 2, M_READY = 3, M_SHUTDN = 4, M_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       hf_tgl = 1'b0;
  logic       clkhfpu, clkhfen, ready, fault;
  logic [2:0] state;

  hfosc_ctrl #(
    .PU_CYCLES(PU), .EDGES_MIN(EMIN), .START_TMO(TMO), .WDOG(WD), .OFF_CYCLES(OFFC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .hf_tgl(hf_tgl),
    .clkhfpu(clkhfpu), .clkhfen(clkhfen), .ready(ready), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: state plus the clock-cycle timestamps that drive its rules
  int   m_st, m_ent, m_last, m_edges, cyc;
  logic h0, h1, h2;
  // oscillator stimulus
  logic lvl = 1'b0;
  int   ph = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_outs(input int s);
    case (s)
      M_PWRUP, M_SHUTDN: exp_outs = 4'b1000;
      M_ENABLE:          exp_outs = 4'b1100;
      M_READY:           exp_outs = 4'b1110;
      M_FAULT:           exp_outs = 4'b0001;
      default:           exp_outs = 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_OFF; m_ent = cyc; m_last = cyc; m_edges = 0;
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
  endtask

  task automatic model_step();
    logic e;
    cyc++;
    // a level change sampled at cycle n is seen as activity at cycle n+2
    e = h1 ^ h2;
    h2 = h1; h1 = h0; h0 = hf_tgl;
    case (m_st)
      M_OFF: if (req) begin m_st = M_PWRUP; m_ent = cyc; end
      M_PWRUP: begin
        if (!req) begin m_st = M_SHUTDN; m_ent = cyc; end
        else if (cyc - m_ent == PU) begin m_st = M_ENABLE; m_ent = cyc; m_edges = 0; end
      end
      M_ENABLE: begin
        if (!req) begin m_st = M_SHUTDN; m_ent = cyc; end
        else if (e && (m_edges + 1 == EMIN)) begin m_st = M_READY; m_last = cyc; end
        else if (cyc - m_ent == TMO) m_st = M_FAULT;
        else if (e) m_edges++;
      end
      M_READY: begin
        if (!req) begin m_st = M_SHUTDN; m_ent = cyc; end
        else if (e) m_last = cyc;
        else if (cyc - m_last == WD) m_st = M_FAULT;
      end
      M_SHUTDN: if (cyc - m_ent == OFFC) m_st = M_OFF;
      M_FAULT:  if (!req) m_st = M_OFF;
      default:  m_st = M_OFF;
    endcase
  endtask

  // drive at negedge, model on posedge, compare at the next negedge
  task automatic step(input logic r, input logic t);
    req = r; hf_tgl = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("state", state, m_st);
    check_eq("outs", {clkhfpu, clkhfen, ready, fault}, exp_outs(m_st));
  endtask

  task automatic osc_tick(input int period);
    if (period > 0) begin
      ph++;
      if (ph >= period) begin ph = 0; lvl = ~lvl; end
    end
  endtask

  task automatic run(input logic r, input int period, input int n);
    for (int i = 0; i < n; i++) begin
      osc_tick(period);
      step(r, lvl);
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq(tag, {29'd0, state} | {27'd0, clkhfpu, clkhfen, ready, fault, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // from OFF: req high, oscillator toggling every 3 cycles
  task automatic startup_timing(input string tag);
    int pu_at, en_at, rdy_at;
    pu_at = -1; en_at = -1; rdy_at = -1; ph = 0;
    for (int k = 1; k <= 130; k++) begin
      osc_tick(3);
      step(1'b1, lvl);
      if (clkhfpu && pu_at < 0) pu_at = k;
      if (clkhfen && en_at < 0) en_at = k;
      if (ready && rdy_at < 0) rdy_at = k;
    end
    check_eq({tag, "_pu_rise"}, pu_at, 1);
    check_eq({tag, "_en_rise"}, en_at, PU + 1);
    check_eq({tag, "_rdy_window"}, (rdy_at > PU + 1) && (rdy_at <= PU + 1 + EMIN * 3 + 3), 1);
    check_eq({tag, "_no_fault"}, fault, 0);
  endtask

  initial begin
    int f_at, en_at, off_at, rdy18, rdy_f, st10;
    bit done;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_state", state, 0);
    check_eq("reset_outs", {clkhfpu, clkhfen, ready, fault}, 0);
    rst_n = 1'b1;
    model_reset();

    // normal start
    startup_timing("start");

    // watchdog: one last toggle, then silence
    run(1'b1, 0, 5);
    lvl = ~lvl;
    f_at = -1; rdy18 = -1; rdy_f = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, lvl);
      if (k == 18) rdy18 = ready;
      if (fault && f_at < 0) begin f_at = k; rdy_f = ready; end
    end
    check_eq("wdog_fault_at", f_at, 3 + WD);
    check_eq("wdog_ready_before", rdy18, 1);
    check_eq("wdog_ready_at_fault", rdy_f, 0);
    step(1'b0, lvl);
    check_eq("wdog_clear", {29'd0, state} + fault, 0);

    // dead oscillator
    en_at = -1; f_at = -1;
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, lvl);
      if (clkhfen && en_at < 0) en_at = k;
      if (fault && f_at < 0) f_at = k;
    end
    check_eq("dead_en_rise", en_at, PU + 1);
    check_eq("dead_fault_at", f_at, PU + 1 + TMO);
    check_eq("dead_fault_outs", {clkhfpu, clkhfen, ready, fault}, 4'b0001);
    step(1'b0, lvl);
    check_eq("dead_clear_fault", fault, 0);
    check_eq("dead_clear_state", state, 0);

    // shutdown with req re-raised while shutting down
    startup_timing("sd");
    check_eq("sd_in_ready", state, 3);
    osc_tick(3);
    step(1'b0, lvl);
    check_eq("sd_drop_outs", {clkhfpu, clkhfen, ready, fault}, 4'b1000);
    off_at = -1; st10 = -1;
    for (int k = 2; k <= 12; k++) begin
      osc_tick(3);
      step(1'b1, lvl);
      if (!clkhfpu && off_at < 0) off_at = k;
      if (k == 10) st10 = state;
    end
    check_eq("sd_pu_off_at", off_at, 1 + OFFC);
    check_eq("sd_restart_state", st10, 1);

    // async reset in ENABLE
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      osc_tick(3);
      step(1'b1, lvl);
      if (m_st == M_ENABLE) done = 1;
    end
    check_eq("en_reached", state, 2);
    async_reset("rst_in_enable");
    startup_timing("rst_en");

    // async reset in READY
    check_eq("rdy_reached", state, 3);
    async_reset("rst_in_ready");
    startup_timing("rst_rdy");

    // req drop coincident with watchdog expiry
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (m_st == M_READY && (cyc + 1 - m_last) == WD) begin
        step(1'b0, lvl);
        done = 1;
      end else begin
        step(1'b1, lvl);
      end
    end
    check_eq("prio_reached", done, 1);
    check_eq("prio_state", state, 4);
    check_eq("prio_fault", fault, 0);
    run(1'b0, 0, OFFC + 2);

    // randomized segments
    for (int s = 0; s < 60; s++) begin
      logic r;
      int   p, n;
      r = ($urandom_range(0, 5) != 0);
      p = $urandom_range(0, 20);
      n = $urandom_range(5, 150);
      run(r, p, n);
      if ($urandom_range(0, 9) == 0) async_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
